// File: rtl/mem_bus_responder.sv
// Responder side of the MEM-stage data bus: on-chip word RAM with byte-lane writes,
// fixed access latency, ack/err completion pulses and a stall request to the pipeline.
module mem_bus_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rw,
    input  logic [3:0]            sel,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ack,
    output logic                  err,
    output logic                  stallreq
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                  state, next_state;
    logic [3:0]              count, next_count;

    logic                    rw_q;
    logic [3:0]              sel_q;
    logic [ADDR_WIDTH-1:0]   index_q;
    logic [31:0]             wdata_q;
    logic                    hit_q;

    logic                    hit_in;
    logic                    accept;
    logic                    commit;
    logic                    op_rw;
    logic                    op_hit;
    logic [3:0]              op_sel;
    logic [ADDR_WIDTH-1:0]   op_index;
    logic [31:0]             op_wdata;

    logic [31:0]             mem [DEPTH];

    // Word access only: the byte offset within a word plays no part in decoding.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign hit_in = (addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign accept = (state == IDLE) && en;

    // With LATENCY==1 the access commits at the accepting edge, so the live bus
    // inputs are used instead of the not-yet-loaded request registers.
    assign op_rw    = accept ? rw                    : rw_q;
    assign op_hit   = accept ? hit_in                : hit_q;
    assign op_sel   = accept ? sel                   : sel_q;
    assign op_index = accept ? addr[ADDR_WIDTH+1:2]  : index_q;
    assign op_wdata = accept ? wdata                 : wdata_q;

    // The RAM/rdata update lands on the edge entering ACK, so data is valid with ack.
    assign commit = (next_state == ACK) && !rst;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        next_count = count;
        unique case (state)
            IDLE: begin
                if (en) begin
                    if (LATENCY == 1) begin
                        next_state = ACK;
                    end else begin
                        next_state = WAIT;
                        next_count = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (!en) begin
                    next_state = IDLE;
                    next_count = 4'd0;
                end else if (count == 4'd1) begin
                    next_state = ACK;
                    next_count = 4'd0;
                end else begin
                    next_count = count - 4'd1;
                end
            end
            ACK: begin
                next_state = IDLE;
                next_count = 4'd0;
            end
            default: begin
                next_state = IDLE;
                next_count = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q    <= rw;
            sel_q   <= sel;
            index_q <= addr[ADDR_WIDTH+1:2];
            wdata_q <= wdata;
            hit_q   <= hit_in;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto plain memory macros.
    always_ff @(posedge clk) begin
        if (commit && op_rw && op_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (op_sel[i]) begin
                    mem[op_index][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'h0;
        end else if (commit && !op_rw) begin
            for (int i = 0; i < 4; i++) begin
                rdata[8*i +: 8] <= (op_hit && op_sel[i]) ? mem[op_index][8*i +: 8] : 8'h00;
            end
        end
    end

    assign ack      = (state == ACK);
    assign err      = ack && !hit_q;
    assign stallreq = en && !ack;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (LATENCY 2, 1, 3) driven by directed
// and random transactions, compared against a word-array reference model.
module tb_mem_bus_responder;

    localparam int LAT [3] = '{2, 1, 3};
    localparam int REGION = 16;

    logic        clk;
    logic        rst;
    logic        en       [3];
    logic        rw       [3];
    logic [3:0]  sel      [3];
    logic [31:0] addr     [3];
    logic [31:0] wdata    [3];
    logic [31:0] rdata    [3];
    logic        ack      [3];
    logic        err      [3];
    logic        stallreq [3];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic [31:0] ref_mem [3][REGION];

    mem_bus_responder #(.ADDR_WIDTH(10), .LATENCY(2), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .rw(rw[0]), .sel(sel[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .stallreq(stallreq[0]));
    mem_bus_responder #(.ADDR_WIDTH(10), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .rw(rw[1]), .sel(sel[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .stallreq(stallreq[1]));
    mem_bus_responder #(.ADDR_WIDTH(10), .LATENCY(3), .BASE_ADDR(32'h0)) dut2 (
        .clk(clk), .rst(rst), .en(en[2]), .rw(rw[2]), .sel(sel[2]), .addr(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .err(err[2]), .stallreq(stallreq[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference read: selected lanes of the stored word, other lanes zero; miss reads zero.
    function automatic logic [31:0] model_read(input int k, input logic [31:0] a, input logic [3:0] s);
        logic [31:0] r = 32'h0;
        if (a < 32'h1000) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) r[8*i +: 8] = ref_mem[k][a[5:2]][8*i +: 8];
        end
        return r;
    endfunction

    function automatic void model_write(input int k, input logic [31:0] a, input logic [3:0] s,
                                        input logic [31:0] d);
        if (a < 32'h1000) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[k][a[5:2]][8*i +: 8] = d[8*i +: 8];
        end
    endfunction

    // One bus access. Inputs go out on a falling edge; the request cycle is cycle 0.
    // With keep=1 en stays high so the next call presents a back-to-back request.
    task automatic txn(input int k, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input bit keep,
                       output logic [31:0] rd, output logic e, output int ack_cyc);
        int lat = 0;
        int stall_n = 0;
        @(negedge clk);
        #1;
        check("no_ack_after_ack", ack[k], 1'b0);
        en[k] = 1'b1; rw[k] = w; sel[k] = s; addr[k] = a; wdata[k] = d;
        #1;
        while (!ack[k] && lat < 40) begin
            if (stallreq[k]) stall_n++;
            @(negedge clk);
            #1;
            lat++;
        end
        check("latency", lat, LAT[k]);
        check("stall_cycles", stall_n, LAT[k]);
        check("stall_in_ack", stallreq[k], 1'b0);
        rd = rdata[k];
        e = err[k];
        ack_cyc = cyc;
        if (!keep) begin
            @(negedge clk);
            en[k] = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd, a, d;
        logic [3:0]  s;
        logic        e, w;
        int          ac, ac_prev;
        bit          keep;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; rw[k] = 1'b0; sel[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_ack", ack[k], 1'b0);
            check("reset_err", err[k], 1'b0);
            check("reset_rdata", rdata[k], 32'h0);
            check("reset_stallreq", stallreq[k], 1'b0);
        end

        // Word write/read, byte lanes and out-of-window accesses at LATENCY=2.
        txn(0, 1'b1, 4'hF, 32'h0000_0000, 32'hA5A5_0F0F, 0, rd, e, ac);
        txn(0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 0, rd, e, ac);
        check("wr_err", e, 1'b0);
        txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 0, rd, e, ac);
        check("rd_word", rd, 32'hDEAD_BEEF);
        check("rd_err", e, 1'b0);
        txn(0, 1'b1, 4'h2, 32'h0000_0010, 32'h0000_5500, 0, rd, e, ac);
        txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 0, rd, e, ac);
        check("rd_lane_merge", rd, 32'hDEAD_55EF);
        txn(0, 1'b0, 4'hC, 32'h0000_0010, 32'h0, 0, rd, e, ac);
        check("rd_lane_mask", rd, 32'hDEAD_0000);
        txn(0, 1'b1, 4'hF, 32'h0000_1000, 32'h1234_5678, 0, rd, e, ac);
        check("miss_wr_err", e, 1'b1);
        txn(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 0, rd, e, ac);
        check("miss_rd_err", e, 1'b1);
        check("miss_rd_data", rd, 32'h0);
        txn(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0, 0, rd, e, ac);
        check("miss_no_alias", rd, 32'hA5A5_0F0F);
        txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 0, rd, e, ac);
        check("after_miss", rd, 32'hDEAD_55EF);
        @(negedge clk);
        #1;
        check("idle_err", err[0], 1'b0);
        check("idle_rdata_hold", rdata[0], 32'hDEAD_55EF);

        // Abort: en dropped during WAIT.
        @(negedge clk);
        en[0] = 1'b1; rw[0] = 1'b1; sel[0] = 4'hF; addr[0] = 32'h10; wdata[0] = 32'h1111_1111;
        @(negedge clk);
        en[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("abort_no_ack", ack[0], 1'b0);
            @(negedge clk);
        end
        txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 0, rd, e, ac);
        check("abort_no_write", rd, 32'hDEAD_55EF);

        // Reset during WAIT of a write.
        @(negedge clk);
        en[0] = 1'b1; rw[0] = 1'b1; sel[0] = 4'hF; addr[0] = 32'h10; wdata[0] = 32'h2222_2222;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en[0] = 1'b0;
        #1;
        check("rst_mid_no_ack", ack[0], 1'b0);
        check("rst_mid_rdata", rdata[0], 32'h0);
        @(negedge clk);
        #1;
        check("rst_mid_idle", ack[0], 1'b0);
        txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 0, rd, e, ac);
        check("rst_mid_no_write", rd, 32'hDEAD_55EF);

        // Throughput: back-to-back reads at LATENCY 1 and 3.
        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 4; i++)
                txn(k, 1'b1, 4'hF, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 0, rd, e, ac);
            for (int i = 0; i < 4; i++) begin
                txn(k, 1'b0, 4'hF, 32'(i * 4), 32'h0, (i != 3), rd, e, ac);
                check("b2b_data", rd, 32'hC0DE_0000 + 32'(i));
                if (i > 0) check("b2b_spacing", ac - ac_prev, LAT[k] + 1);
                ac_prev = ac;
            end
        end

        // Random traffic against the reference model on all three instances.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < REGION; i++) begin
                d = $urandom();
                txn(k, 1'b1, 4'hF, 32'(i * 4), d, 0, rd, e, ac);
                ref_mem[k][i] = d;
            end
            for (int n = 0; n < 40; n++) begin
                w = 1'($urandom_range(0, 1));
                s = 4'($urandom_range(0, 15));
                d = $urandom();
                if ($urandom_range(0, 4) == 0) a = $urandom() | 32'h0000_1000;
                else a = 32'($urandom_range(0, REGION - 1) * 4 + $urandom_range(0, 3));
                keep = ($urandom_range(0, 1) == 1) && (n != 39);
                txn(k, w, s, a, d, keep, rd, e, ac);
                check("rand_err", e, (a >= 32'h1000));
                if (w) model_write(k, a, s, d);
                else check("rand_rdata", rd, model_read(k, a, s));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
